bp_cce_gad_ctrl: RTL
====================

BP_CCE_GAD_CTRL -- requirements
Module: bp_cce_gad_ctrl

Interface
REQ-001 Parameter num_lce_p, default 8: number of LCEs tracked per way-group.
REQ-002 Parameter lce_assoc_p, default 8: LCE associativity; lce_assoc_width_p = clog2(lce_assoc_p).
REQ-003 Parameter lce_per_row_p, default 2: LCE entries per directory RAM row; rows_lp = num_lce_p/lce_per_row_p (default 4).
REQ-004 clk_i  in  1  sole clock.
REQ-005 reset_n_i  in  1  reset, asynchronous, active-low.
REQ-006 req_v_i / req_ready_o  in/out  1/1  GAD request handshake.
REQ-007 req_wg_i  in  wg_width_p  way-group index of target address.
REQ-008 dir_r_v_o / dir_r_ready_i  out/in  1/1  directory row-read handshake.
REQ-009 dir_r_addr_o  out  wg_width_p+clog2(rows_lp)  {way-group, row}.
REQ-010 dir_data_v_i / dir_data_i  in  1 / lce_per_row_p*(1+lce_assoc_width_p+3)  row data; entry = {valid, way, coh_state}, LCE 0 at LSBs.
REQ-011 sharers_v_o / sharers_yumi_i  out/in  1/1  assembled result handshake.
REQ-012 sharers_hits_o, sharers_ways_o, sharers_coh_states_o  out  num_lce_p, num_lce_p*lce_assoc_width_p, num_lce_p*3  per-LCE directory view for GAD.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 err_o  out  1  owner-conflict flag (see Configuration).

Function
REQ-015 FSM states IDLE, READ, DRAIN, DONE.
REQ-016 IDLE: req_ready_o=1; req_v_i captures req_wg_i, clears row/return counters and result registers, goes READ.
REQ-017 READ: dir_r_v_o=1, dir_r_addr_o={wg, issue_cnt}; issue_cnt increments only on dir_r_v_o & dir_r_ready_i; after row rows_lp-1 is accepted, goes DRAIN.
REQ-018 Directory returns data exactly one cycle after each accepted read; dir_data_v_i writes row return_cnt into the result slots for LCEs return_cnt*lce_per_row_p .. +lce_per_row_p-1.
REQ-019 Issue and return overlap; with dir_r_ready_i always high, row r is issued in cycle r+1 after acceptance, and its data is captured in cycle r+2.
REQ-020 DRAIN: when return_cnt reaches rows_lp (last row captured), goes DONE; with no stalls, sharers_v_o rises in cycle rows_lp+2 after acceptance (cycle 6 at defaults).
REQ-021 DONE: sharers_v_o=1 and outputs held stable until sharers_yumi_i; yumi returns to IDLE; next request can be accepted in the following cycle.
REQ-022 sharers_hits_o[i] = captured valid bit; an invalid entry forces its way to 0 and its state to e_COH_I on the outputs.
REQ-023 dir_data_v_i in IDLE or DONE is ignored; dir_data_v_i beyond rows_lp rows is ignored.
REQ-024 sharers_yumi_i outside DONE and req_v_i outside IDLE are ignored.
REQ-025 Counters are clog2(rows_lp)+1 bits wide; they never wrap within one request.

Reset
REQ-026 Asynchronous assertion of reset_n_i forces IDLE immediately, including mid-READ/DRAIN/DONE; the in-flight request is discarded.
REQ-027 Reset values: req_ready_o=1 (once in IDLE), dir_r_v_o=0, sharers_v_o=0, busy_o=0, err_o=0, all result/counter registers 0, coh states e_COH_I.

Configuration
REQ-028 Macro BP_CCE_GAD_CTRL_OWNER_CHECK_EN: when defined, err_o is set in DONE when more than one LCE holds E, M, O or F, and it is cleared on yumi; when undefined, err_o is tied to 0 and no check logic exists.

Structure
REQ-029 bp_cce_pkg holds the directory row-entry struct {valid, way, coh_state} and the FSM state enum; bp_coh_states_e is reused.
REQ-030 One sub-module, bp_cce_dir_row_unpack, splits a row into per-LCE valid/way/state fields.

Verification
REQ-031 Defaults, wg=5, dir_r_ready_i=1, rows return LCE2=M way3 and all other entries invalid -> rows 0..3 issued in cycles 1..4 at dir_r_addr_o={5,0..3}; sharers_v_o in cycle 6; hits=8'h04, way[2]=3, state[2]=e_COH_M.
REQ-032 dir_r_ready_i low for 2 cycles on row 1 -> row 1 is reissued with the same address; sharers_v_o is delayed by 2 cycles (cycle 8); data is correct.
REQ-033 sharers_yumi_i held low for 10 cycles in DONE -> outputs are stable, req_ready_o=0, and a new req_v_i is not accepted; yumi leads to IDLE, and a new request is accepted the next cycle.
REQ-034 reset_n_i asserted in cycle 3 of READ -> outputs immediately take their reset values; a subsequent request completes normally with no stale data.
REQ-035 With the macro defined, LCE0=E and LCE5=O -> err_o=1 together with sharers_v_o; LCE0=S and LCE5=S -> err_o=0; with the macro undefined, the first case gives err_o=0.
REQ-036 A spurious dir_data_v_i in IDLE -> no change to any output.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// Shared CCE types: coherence states, directory row-entry layout and GAD controller FSM states.
package bp_cce_pkg;

    typedef enum logic [2:0] {
        e_COH_I = 3'b000,
        e_COH_S = 3'b001,
        e_COH_E = 3'b010,
        e_COH_F = 3'b011,
        e_COH_M = 3'b110,
        e_COH_O = 3'b111
    } bp_coh_states_e;

    localparam int bp_cce_dir_way_width_gp = 3;

    // One LCE slot in a directory row; valid is the MSB, coh_state sits at the LSBs.
    typedef struct packed {
        logic                               valid;
        logic [bp_cce_dir_way_width_gp-1:0] way;
        bp_coh_states_e                     coh_state;
    } bp_cce_dir_entry_s;

    typedef enum logic [1:0] {
        e_GAD_IDLE  = 2'd0,
        e_GAD_READ  = 2'd1,
        e_GAD_DRAIN = 2'd2,
        e_GAD_DONE  = 2'd3
    } bp_cce_gad_state_e;

    // States in which an LCE is responsible for supplying the block.
    function automatic logic bp_coh_is_owner(input bp_coh_states_e s);
        return (s == e_COH_E) || (s == e_COH_M) || (s == e_COH_O) || (s == e_COH_F);
    endfunction

endpackage

// File: rtl/bp_cce_dir_row_unpack.sv
// Splits one directory RAM row into per-LCE valid/way/coherence-state fields.
module bp_cce_dir_row_unpack
    import bp_cce_pkg::*;
#(
    parameter  int lce_per_row_p  = 2,
    parameter  int way_width_p    = 3,
    localparam int entry_width_lp = 1 + way_width_p + 3
) (
    input  logic [lce_per_row_p*entry_width_lp-1:0] row_i,
    output logic [lce_per_row_p-1:0]                valid_o,
    output logic [lce_per_row_p*way_width_p-1:0]    way_o,
    output logic [lce_per_row_p*3-1:0]              state_o
);

    for (genvar j = 0; j < lce_per_row_p; j++) begin : g_entry
        assign state_o[j*3 +: 3]                 = row_i[j*entry_width_lp +: 3];
        assign way_o[j*way_width_p +: way_width_p] = row_i[j*entry_width_lp+3 +: way_width_p];
        assign valid_o[j]                        = row_i[j*entry_width_lp+3+way_width_p];
    end

endmodule

// File: rtl/bp_cce_gad_ctrl.sv
// Gathers a way-group's directory rows into a per-LCE sharer view for the GAD stage.
// Optional owner-conflict check is enabled by defining BP_CCE_GAD_CTRL_OWNER_CHECK_EN.
module bp_cce_gad_ctrl
    import bp_cce_pkg::*;
#(
    parameter  int num_lce_p         = 8,
    parameter  int lce_assoc_p       = 8,
    parameter  int lce_per_row_p     = 2,
    parameter  int wg_width_p        = 4,
    localparam int lce_assoc_width_p = $clog2(lce_assoc_p),
    localparam int rows_lp           = num_lce_p / lce_per_row_p,
    localparam int row_w_lp          = $clog2(rows_lp),
    localparam int cnt_w_lp          = row_w_lp + 1,
    localparam int entry_w_lp        = 1 + lce_assoc_width_p + 3
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    // Request: valid/ready, transfer on req_v_i & req_ready_o at a rising edge.
    // Directory read and result use the same rule; sharers_yumi_i is a consume strobe
    // that is only honoured while sharers_v_o is high.
    input  logic                                   req_v_i,
    output logic                                   req_ready_o,
    input  logic [wg_width_p-1:0]                  req_wg_i,

    output logic                                   dir_r_v_o,
    input  logic                                   dir_r_ready_i,
    output logic [wg_width_p+row_w_lp-1:0]         dir_r_addr_o,

    input  logic                                   dir_data_v_i,
    input  logic [lce_per_row_p*entry_w_lp-1:0]    dir_data_i,

    output logic                                   sharers_v_o,
    input  logic                                   sharers_yumi_i,
    output logic [num_lce_p-1:0]                   sharers_hits_o,
    output logic [num_lce_p*lce_assoc_width_p-1:0] sharers_ways_o,
    output logic [num_lce_p*3-1:0]                 sharers_coh_states_o,

    output logic                                   busy_o,
    output logic                                   err_o,
    output logic [1:0]                             state_o
);

    bp_cce_gad_state_e state_r, state_n;

    logic [wg_width_p-1:0]                  wg_r;
    logic [cnt_w_lp-1:0]                    issue_cnt_r;
    logic [cnt_w_lp-1:0]                    return_cnt_r;
    logic [num_lce_p-1:0]                   hit_r;
    logic [num_lce_p*lce_assoc_width_p-1:0] way_r;
    logic [num_lce_p*3-1:0]                 coh_r;

    logic accept;
    logic issue;
    logic take;
    logic last_issue;
    logic last_return;

    logic [lce_per_row_p-1:0]                   row_valid;
    logic [lce_per_row_p*lce_assoc_width_p-1:0] row_way;
    logic [lce_per_row_p*3-1:0]                 row_state;

    bp_cce_dir_row_unpack #(
        .lce_per_row_p (lce_per_row_p),
        .way_width_p   (lce_assoc_width_p)
    ) u_unpack (
        .row_i   (dir_data_i),
        .valid_o (row_valid),
        .way_o   (row_way),
        .state_o (row_state)
    );

    // Returns are only meaningful while a request is in flight and rows are still owed.
    assign take = dir_data_v_i
                  && ((state_r == e_GAD_READ) || (state_r == e_GAD_DRAIN))
                  && (return_cnt_r < cnt_w_lp'(rows_lp));
    assign last_issue  = (issue_cnt_r == cnt_w_lp'(rows_lp - 1));
    assign last_return = (return_cnt_r == cnt_w_lp'(rows_lp))
                         || (take && (return_cnt_r == cnt_w_lp'(rows_lp - 1)));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_GAD_IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n     = state_r;
        req_ready_o = 1'b0;
        dir_r_v_o   = 1'b0;
        sharers_v_o = 1'b0;
        accept      = 1'b0;
        issue       = 1'b0;
        case (state_r)
            e_GAD_IDLE: begin
                req_ready_o = 1'b1;
                if (req_v_i) begin
                    accept  = 1'b1;
                    state_n = e_GAD_READ;
                end
            end
            e_GAD_READ: begin
                dir_r_v_o = 1'b1;
                if (dir_r_ready_i) begin
                    issue = 1'b1;
                    if (last_issue) state_n = e_GAD_DRAIN;
                end
            end
            e_GAD_DRAIN: begin
                if (last_return) state_n = e_GAD_DONE;
            end
            e_GAD_DONE: begin
                sharers_v_o = 1'b1;
                if (sharers_yumi_i) state_n = e_GAD_IDLE;
            end
            default: state_n = e_GAD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wg_r         <= '0;
            issue_cnt_r  <= '0;
            return_cnt_r <= '0;
        end else if (accept) begin
            wg_r         <= req_wg_i;
            issue_cnt_r  <= '0;
            return_cnt_r <= '0;
        end else begin
            if (issue) issue_cnt_r  <= issue_cnt_r + 1'b1;
            if (take)  return_cnt_r <= return_cnt_r + 1'b1;
        end
    end

    // Row return_cnt_r lands in LCE slots return_cnt_r*lce_per_row_p onward.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hit_r <= '0;
            way_r <= '0;
            coh_r <= '0;
        end else if (accept) begin
            hit_r <= '0;
            way_r <= '0;
            coh_r <= '0;
        end else if (take) begin
            for (int r = 0; r < rows_lp; r++) begin
                if (return_cnt_r == cnt_w_lp'(r)) begin
                    for (int j = 0; j < lce_per_row_p; j++) begin
                        hit_r[r*lce_per_row_p+j] <= row_valid[j];
                        way_r[(r*lce_per_row_p+j)*lce_assoc_width_p +: lce_assoc_width_p]
                            <= row_way[j*lce_assoc_width_p +: lce_assoc_width_p];
                        coh_r[(r*lce_per_row_p+j)*3 +: 3] <= row_state[j*3 +: 3];
                    end
                end
            end
        end
    end

    always_comb begin
        sharers_hits_o       = hit_r;
        sharers_ways_o       = '0;
        sharers_coh_states_o = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            sharers_ways_o[i*lce_assoc_width_p +: lce_assoc_width_p] =
                hit_r[i] ? way_r[i*lce_assoc_width_p +: lce_assoc_width_p] : '0;
            sharers_coh_states_o[i*3 +: 3] = hit_r[i] ? coh_r[i*3 +: 3] : e_COH_I;
        end
    end

    assign dir_r_addr_o = {wg_r, issue_cnt_r[row_w_lp-1:0]};
    assign busy_o       = (state_r != e_GAD_IDLE);
    assign state_o      = state_r;

`ifdef BP_CCE_GAD_CTRL_OWNER_CHECK_EN
    logic owner_seen;
    logic owner_multi;

    always_comb begin
        owner_seen  = 1'b0;
        owner_multi = 1'b0;
        for (int i = 0; i < num_lce_p; i++) begin
            if (hit_r[i] && bp_coh_is_owner(bp_coh_states_e'(coh_r[i*3 +: 3]))) begin
                if (owner_seen) owner_multi = 1'b1;
                owner_seen = 1'b1;
            end
        end
    end

    // Result registers are frozen in DONE, so this holds until yumi leaves DONE.
    assign err_o = (state_r == e_GAD_DONE) && owner_multi;
`else
    assign err_o = 1'b0;
`endif

endmodule
